// File: rtl/ksa_out_refresh.sv
// ksa_out_refresh: pipelined Boolean-mask refresh placed after the masked
// Kogge-Stone adder. N_SHARES-1 registered rounds, each round XORs fresh
// randomness into pairs of shares so the unmasked value is preserved.
// Optional feature macro: FULL_REFRESH_EN
//   defined     -> quadratic refresh, round j pairs share j with every share i<j
//   not defined -> linear refresh, round j pairs share j with share 0 only
module ksa_out_refresh #(
  parameter int K_WIDTH   = 32,
  parameter int N_SHARES  = 3,
  parameter int MASKWIDTH = K_WIDTH * N_SHARES,
`ifdef FULL_REFRESH_EN
  parameter int RANDNUM   = N_SHARES * (N_SHARES - 1) / 2
`else
  parameter int RANDNUM   = N_SHARES - 1
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dvld,
  input  logic                       ena,
  input  logic [K_WIDTH*RANDNUM-1:0] rnd,
  input  logic [MASKWIDTH-1:0]       x,
  output logic [MASKWIDTH-1:0]       z,
  output logic                       ovld
);

  localparam int NSTG = N_SHARES - 1;

  // Stage s (0-based) implements refresh round j = s+1.
  logic [MASKWIDTH-1:0] r_data [NSTG];
  logic [NSTG-1:0]      r_vld;

  logic [MASKWIDTH-1:0] w_src  [NSTG];
  logic [MASKWIDTH-1:0] w_next [NSTG];
  logic [NSTG-1:0]      w_vsrc;

  // Select each stage's upstream word: x/dvld for the first round, the
  // previous stage register otherwise.
  always_comb begin
    w_src[0]  = x;
    w_vsrc    = '0;
    w_vsrc[0] = dvld;
    for (int s = 1; s < NSTG; s++) begin
      w_src[s]  = r_data[s-1];
      w_vsrc[s] = r_vld[s-1];
    end
  end

  // Per-round XOR network; each stage only touches its own rnd slices, so
  // words in flight in the same cycle never share randomness.
  always_comb begin
    logic [K_WIDTH-1:0] w_r;
    w_r = '0;
    for (int s = 0; s < NSTG; s++) begin
      w_next[s] = w_src[s];
`ifdef FULL_REFRESH_EN
      for (int i = 0; i < NSTG; i++) begin
        if (i <= s) begin
          w_r = rnd[(((s + 1) * s) / 2 + i) * K_WIDTH +: K_WIDTH];
          w_next[s][i*K_WIDTH +: K_WIDTH] =
            w_next[s][i*K_WIDTH +: K_WIDTH] ^ w_r;
          w_next[s][(s+1)*K_WIDTH +: K_WIDTH] =
            w_next[s][(s+1)*K_WIDTH +: K_WIDTH] ^ w_r;
        end
      end
`else
      w_r = rnd[s*K_WIDTH +: K_WIDTH];
      w_next[s][0 +: K_WIDTH] = w_next[s][0 +: K_WIDTH] ^ w_r;
      w_next[s][(s+1)*K_WIDTH +: K_WIDTH] =
        w_next[s][(s+1)*K_WIDTH +: K_WIDTH] ^ w_r;
`endif
    end
  end

  // Pipeline registers: reset clears everything, ena=0 freezes data and
  // valids together. Data loads even behind a bubble so it never goes X.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NSTG; s++) r_data[s] <= '0;
      r_vld <= '0;
    end else if (ena) begin
      for (int s = 0; s < NSTG; s++) r_data[s] <= w_next[s];
      r_vld <= w_vsrc;
    end
  end

  assign z    = r_data[NSTG-1];
  assign ovld = r_vld[NSTG-1];

endmodule
